// File: rtl/adpll_pkg.sv
// adpll_pkg: types and constants shared across the ADPLL datapath.
//   nco_state_e           - oscillator control states (IDLE / RUN / DRAIN)
//   DCO_CC_WIDTH_DEFAULT  - control-code width shared by the loop filter and
//                           the NCO, so both ends of the code bus agree.
package adpll_pkg;

  localparam int DCO_CC_WIDTH_DEFAULT = 32'sd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } nco_state_e;

endpackage

// File: rtl/dco_fcw_calc.sv
// dco_fcw_calc: combinational frequency-control-word calculation.
//   fcw = clamp(CENTRE_FCW + (sign-extended cc_code << CC_SHIFT), FCW_MIN, FCW_MAX)
// Ports:
//   cc_code     in  signed [DCO_CC_WIDTH-1:0]  registered loop-filter code
//   fcw_clamped out [ACC_WIDTH-1:0]            clamped frequency control word
//   fcw_sat     out 1 bit                      high when the clamp was applied
// The sum is formed in ACC_WIDTH+2 signed bits, which must be wider than
// DCO_CC_WIDTH so the sign extension below is well formed.
module dco_fcw_calc
  import adpll_pkg::*;
#(
  parameter int                   DCO_CC_WIDTH = DCO_CC_WIDTH_DEFAULT,
  parameter int                   ACC_WIDTH    = 32'sd24,
  parameter logic [ACC_WIDTH-1:0] CENTRE_FCW   = 24'h020000,
  parameter int                   CC_SHIFT     = 32'sd4,
  parameter logic [ACC_WIDTH-1:0] FCW_MIN      = {{(ACC_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [ACC_WIDTH-1:0] FCW_MAX      = {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
  input  logic signed [DCO_CC_WIDTH-1:0] cc_code,
  output logic        [ACC_WIDTH-1:0]    fcw_clamped,
  output logic                           fcw_sat
);

  localparam int CALC_W = ACC_WIDTH + 32'sd2;

  logic signed [CALC_W-1:0] cc_ext_s;
  logic signed [CALC_W-1:0] sum_s;
  logic signed [CALC_W-1:0] min_s;
  logic signed [CALC_W-1:0] max_s;

  // Signed sum of centre word and scaled control code, then clamp.
  always_comb begin
    cc_ext_s    = {{(CALC_W-DCO_CC_WIDTH){cc_code[DCO_CC_WIDTH-1]}}, cc_code};
    sum_s       = $signed({2'b00, CENTRE_FCW}) + (cc_ext_s <<< CC_SHIFT);
    min_s       = $signed({2'b00, FCW_MIN});
    max_s       = $signed({2'b00, FCW_MAX});
    fcw_clamped = CENTRE_FCW;
    fcw_sat     = 1'b0;
    if (sum_s > max_s) begin
      fcw_clamped = FCW_MAX;
      fcw_sat     = 1'b1;
    end else if (sum_s < min_s) begin
      fcw_clamped = FCW_MIN;
      fcw_sat     = 1'b1;
    end else begin
      fcw_clamped = sum_s[ACC_WIDTH-1:0];
      fcw_sat     = 1'b0;
    end
  end

endmodule

// File: rtl/dco_nco.sv
// dco_nco: digitally controlled oscillator built from a phase accumulator.
// Ports:
//   gen_clk_i  in   1 bit   only clock
//   reset_i    in   1 bit   synchronous active-high reset
//   dco_cc_i   in   signed [DCO_CC_WIDTH-1:0]  loop-filter control code
//   enable_i   in   1 bit   oscillator run request
//   dco_clk_o  out  1 bit   square wave = accumulator MSB
//   fb_clk_o   out  1 bit   dco_clk divided by FB_DIV (phase detector feedback)
//   wrap_o     out  1 bit   one-cycle pulse after each accumulator overflow
//   sat_o      out  1 bit   active FCW was clamped
//   fcw_o      out  [ACC_WIDTH-1:0] active FCW
// The FCW is only reloaded in IDLE or on the overflow edge, so a new
// frequency always starts on a fresh period. Stopping is graceful: DRAIN
// finishes the current period before parking in IDLE.
module dco_nco
  import adpll_pkg::*;
#(
  parameter int                   DCO_CC_WIDTH = DCO_CC_WIDTH_DEFAULT,
  parameter int                   ACC_WIDTH    = 32'sd24,
  parameter logic [ACC_WIDTH-1:0] CENTRE_FCW   = 24'h020000,
  parameter int                   CC_SHIFT     = 32'sd4,
  parameter logic [ACC_WIDTH-1:0] FCW_MIN      = {{(ACC_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [ACC_WIDTH-1:0] FCW_MAX      = {1'b1, {(ACC_WIDTH-1){1'b0}}},
  parameter int                   FB_DIV       = 32'sd8
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  input  logic                           enable_i,
  output logic                           dco_clk_o,
  output logic                           fb_clk_o,
  output logic                           wrap_o,
  output logic                           sat_o,
  output logic        [ACC_WIDTH-1:0]    fcw_o
);

  localparam int                CNT_W    = $clog2(FB_DIV);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(FB_DIV / 32'sd2 - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FB_DIV - 32'sd1);

  nco_state_e                     state_r, state_s;
  logic        [ACC_WIDTH-1:0]    acc_r, acc_s;
  logic signed [DCO_CC_WIDTH-1:0] cc_r;
  logic        [ACC_WIDTH-1:0]    fcw_r;
  logic                           sat_r;
  logic                           wrap_r, wrap_s;
  logic                           fb_clk_r, fb_clk_s;
  logic        [CNT_W-1:0]        cnt_r, cnt_s;
  logic        [ACC_WIDTH:0]      sum_s;
  logic                           carry_s;
  logic                           load_s;
  logic        [ACC_WIDTH-1:0]    fcw_calc_s;
  logic                           sat_calc_s;

  dco_fcw_calc #(
    .DCO_CC_WIDTH (DCO_CC_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .CENTRE_FCW   (CENTRE_FCW),
    .CC_SHIFT     (CC_SHIFT),
    .FCW_MIN      (FCW_MIN),
    .FCW_MAX      (FCW_MAX)
  ) u_fcw_calc (
    .cc_code     (cc_r),
    .fcw_clamped (fcw_calc_s),
    .fcw_sat     (sat_calc_s)
  );

  // Next-state, accumulator, wrap pulse and feedback divider logic.
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, fcw_r};
    carry_s  = sum_s[ACC_WIDTH];
    state_s  = state_r;
    acc_s    = acc_r;
    load_s   = 1'b0;
    wrap_s   = 1'b0;
    cnt_s    = cnt_r;
    fb_clk_s = fb_clk_r;

    case (state_r)
      IDLE: begin
        acc_s  = {ACC_WIDTH{1'b0}};
        load_s = 1'b1;
        if (enable_i) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s  = sum_s[ACC_WIDTH-1:0];
        load_s = carry_s;
        if (!enable_i) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        acc_s  = sum_s[ACC_WIDTH-1:0];
        load_s = carry_s;
        // A re-raised enable takes priority over the final overflow, and
        // keeps the accumulator phase continuous.
        if (enable_i) begin
          state_s = RUN;
        end else if (carry_s) begin
          state_s = IDLE;
          acc_s   = {ACC_WIDTH{1'b0}};
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = {ACC_WIDTH{1'b0}};
      end
    endcase

    // Parking in IDLE silences every output, including the last wrap.
    if (state_s == IDLE) begin
      wrap_s   = 1'b0;
      cnt_s    = {CNT_W{1'b0}};
      fb_clk_s = 1'b0;
    end else if ((state_r != IDLE) && carry_s) begin
      wrap_s = 1'b1;
      if (cnt_r == CNT_LAST) begin
        cnt_s = {CNT_W{1'b0}};
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
      // Toggle at the middle and end of each FB_DIV-wrap cycle.
      if ((cnt_r == CNT_HALF) || (cnt_r == CNT_LAST)) begin
        fb_clk_s = ~fb_clk_r;
      end else begin
        fb_clk_s = fb_clk_r;
      end
    end else begin
      wrap_s   = 1'b0;
      cnt_s    = cnt_r;
      fb_clk_s = fb_clk_r;
    end
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      acc_r    <= {ACC_WIDTH{1'b0}};
      cc_r     <= {DCO_CC_WIDTH{1'b0}};
      fcw_r    <= CENTRE_FCW;
      sat_r    <= 1'b0;
      wrap_r   <= 1'b0;
      fb_clk_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      cc_r     <= dco_cc_i;
      wrap_r   <= wrap_s;
      fb_clk_r <= fb_clk_s;
      cnt_r    <= cnt_s;
      if (load_s) begin
        fcw_r <= fcw_calc_s;
        sat_r <= sat_calc_s;
      end
    end
  end

  assign dco_clk_o = acc_r[ACC_WIDTH-1];
  assign fb_clk_o  = fb_clk_r;
  assign wrap_o    = wrap_r;
  assign sat_o     = sat_r;
  assign fcw_o     = fcw_r;

endmodule

// File: tb/tb_dco_nco.sv
// tb_dco_nco: directed self-checking bench for dco_nco with
// ACC_WIDTH=8, CENTRE_FCW=16, CC_SHIFT=0, FCW 1..128, FB_DIV=4.
module tb_dco_nco;

  logic              gen_clk_i = 1'b0;
  logic              reset_i;
  logic signed [8:0] dco_cc_i;
  logic              enable_i;
  logic              dco_clk_o;
  logic              fb_clk_o;
  logic              wrap_o;
  logic              sat_o;
  logic [7:0]        fcw_o;

  int n_checks = 0;
  int n_pass   = 0;

  dco_nco #(
    .DCO_CC_WIDTH (9),
    .ACC_WIDTH    (8),
    .CENTRE_FCW   (8'd16),
    .CC_SHIFT     (0),
    .FCW_MIN      (8'd1),
    .FCW_MAX      (8'd128),
    .FB_DIV       (4)
  ) dut (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .dco_cc_i  (dco_cc_i),
    .enable_i  (enable_i),
    .dco_clk_o (dco_clk_o),
    .fb_clk_o  (fb_clk_o),
    .wrap_o    (wrap_o),
    .sat_o     (sat_o),
    .fcw_o     (fcw_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge gen_clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until wrap_o (bounded), checking length, high count and that
  // fcw_o changes only on the wrap cycle.
  task automatic run_period(input string tag, input int exp_len, input int exp_high);
    int len, high, stable, start_fcw;
    len = 0; high = 0; stable = 1; start_fcw = fcw_o;
    for (int i = 0; i < 400; i++) begin
      tick();
      len++;
      if (dco_clk_o) high++;
      if (wrap_o) break;
      if (fcw_o != start_fcw) stable = 0;
    end
    check_eq({tag, "_len"}, len, exp_len);
    check_eq({tag, "_high"}, high, exp_high);
    check_eq({tag, "_fcw_held"}, stable, 1);
  endtask

  initial begin
    int hi, wr, fb;
    reset_i = 1'b1; enable_i = 1'b0; dco_cc_i = 9'sd0;
    ticks(2);
    check_eq("rst_dco", dco_clk_o, 0);
    check_eq("rst_fb", fb_clk_o, 0);
    check_eq("rst_wrap", wrap_o, 0);
    check_eq("rst_sat", sat_o, 0);
    check_eq("rst_fcw", fcw_o, 16);
    reset_i = 1'b0;
    tick();

    // Free run at centre frequency: first wrap 16 cycles after enable seen.
    enable_i = 1'b1;
    run_period("p1", 17, 8);
    check_eq("fb_w1", fb_clk_o, 0);
    run_period("p2", 16, 8);
    check_eq("fb_w2", fb_clk_o, 1);
    run_period("p3", 16, 8);
    check_eq("fb_w3", fb_clk_o, 1);
    run_period("p4", 16, 8);
    check_eq("fb_w4", fb_clk_o, 0);
    check_eq("centre_fcw", fcw_o, 16);
    check_eq("centre_sat", sat_o, 0);

    // Mid-period step: current period finishes at 16, next runs at 8.
    ticks(3);
    dco_cc_i = 9'sd16;
    run_period("step_cur", 13, 8);
    check_eq("step_fcw", fcw_o, 32);
    run_period("step_new", 8, 4);

    // Clamp limits.
    dco_cc_i = 9'sd200;
    run_period("sat_hi_p", 8, 4);
    check_eq("sat_hi_fcw", fcw_o, 128);
    check_eq("sat_hi_flag", sat_o, 1);
    dco_cc_i = -9'sd16;
    run_period("sat_lo_p", 2, 1);
    check_eq("sat_lo_fcw", fcw_o, 1);
    check_eq("sat_lo_flag", sat_o, 1);
    dco_cc_i = -9'sd15;
    run_period("min_p", 256, 128);
    check_eq("min_fcw", fcw_o, 1);
    check_eq("min_flag", sat_o, 0);
    dco_cc_i = 9'sd0;
    run_period("min_p2", 256, 128);
    check_eq("back_fcw", fcw_o, 16);

    // Drop enable at acc=0x40: drain to the overflow, then silent IDLE.
    ticks(4);
    enable_i = 1'b0;
    hi = 0; wr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dco_clk_o) hi++;
      if (wrap_o) wr++;
    end
    check_eq("drain_high", hi, 8);
    check_eq("drain_wraps", wr, 0);
    check_eq("idle_dco", dco_clk_o, 0);
    check_eq("idle_fb", fb_clk_o, 0);
    hi = 0; wr = 0; fb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dco_clk_o) hi++;
      if (wrap_o) wr++;
      if (fb_clk_o) fb++;
    end
    check_eq("idle_quiet", hi + wr + fb, 0);

    // Restart, then re-raise enable during DRAIN: phase stays continuous.
    enable_i = 1'b1;
    run_period("restart", 17, 8);
    ticks(4);
    enable_i = 1'b0;
    ticks(5);
    enable_i = 1'b1;
    run_period("reenter", 7, 6);
    run_period("after_reenter", 16, 8);

    // Enable re-raised exactly on the final overflow: RUN wins.
    ticks(4);
    enable_i = 1'b0;
    ticks(11);
    enable_i = 1'b1;
    tick();
    check_eq("race_wrap", wrap_o, 1);
    run_period("race_next", 16, 8);

    // Reset mid-period cuts everything back to the reset state.
    dco_cc_i = 9'sd16;
    run_period("pre_rst", 16, 8);
    check_eq("pre_rst_fcw", fcw_o, 32);
    ticks(5);
    reset_i = 1'b1;
    dco_cc_i = 9'sd0;
    tick();
    check_eq("mid_rst_dco", dco_clk_o, 0);
    check_eq("mid_rst_fb", fb_clk_o, 0);
    check_eq("mid_rst_wrap", wrap_o, 0);
    check_eq("mid_rst_sat", sat_o, 0);
    check_eq("mid_rst_fcw", fcw_o, 16);
    reset_i = 1'b0;
    run_period("post_rst", 17, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
